// File: rtl/fpu_pkg.sv
// Shared single-precision field widths, FTZ constant and unpacked-float type for the FPU blocks.
package fpu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;

  localparam logic [EXP_W+MANT_W:0] FTZ_ZERO = '0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   mant;  // hidden bit included
  } fp_unpacked_t;

  // Denormals and zeros collapse to +0 with a zero mantissa.
  function automatic fp_unpacked_t fp_unpack(input logic [EXP_W+MANT_W:0] x);
    fp_unpacked_t f;
    if (x[EXP_W+MANT_W-1:MANT_W] == '0) begin
      f = '0;
    end else begin
      f.sign = x[EXP_W+MANT_W];
      f.exp  = x[EXP_W+MANT_W-1:MANT_W];
      f.mant = {1'b1, x[MANT_W-1:0]};
    end
    return f;
  endfunction

endpackage

// File: rtl/fpu_norm_lzc.sv
// Leading-one detector over bits [25:1] and left-normalizer; bit 0 only rides along in the shift.
module fpu_norm_lzc (
  input  logic [25:0] in_i,
  output logic [4:0]  shift_o,
  output logic [25:0] norm_o,
  output logic        zero_o
);

  always_comb begin
    shift_o = 5'd0;
    zero_o  = 1'b1;
    // Ascending scan: the highest set bit is the last one written.
    for (int i = 1; i < 26; i++) begin
      if (in_i[i]) begin
        shift_o = 5'(25 - i);
        zero_o  = 1'b0;
      end
    end
    norm_o = in_i << shift_o;
  end

endmodule

// File: rtl/fsub_pipe.sv
// Two-stage pipelined FP32 subtractor y = x1 - x2 with valid/ready on both sides.
module fsub_pipe
  import fpu_pkg::*;
#(
  parameter bit GB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  typedef struct packed {
    fp_unpacked_t lg;
    logic [23:0]  sm_mant;
    logic         guard;
    logic         eff_add;
  } s1_t;

  logic        s1_valid_q, s2_valid_q;
  s1_t         s1_q, s1_d;
  logic [31:0] y_q, y_d;
  logic        s1_load, s2_load;

  assign s2_load   = !s2_valid_q || out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign y         = y_q;

  // Stage 1: unpack, order by magnitude, align the smaller operand.
  fp_unpacked_t a, b, lg, sm;
  logic         a_larger;
  logic [7:0]   d;

  always_comb begin
    a      = fp_unpack(x1);
    b      = fp_unpack(x2);
    b.sign = ~b.sign;
    // Tie goes to x2 so equal magnitudes take the negated subtrahend sign.
    a_larger = {a.exp, a.mant[MANT_W-1:0]} > {b.exp, b.mant[MANT_W-1:0]};
    lg       = a_larger ? a : b;
    sm       = a_larger ? b : a;
    d        = lg.exp - sm.exp;
    s1_d         = '0;
    s1_d.lg      = lg;
    s1_d.eff_add = (a.sign == b.sign);
    if (d <= 8'd24) begin
      s1_d.sm_mant = sm.mant >> d;
      s1_d.guard   = GB_EN && (d != 8'd0) && |(sm.mant & (24'd1 << (d - 8'd1)));
    end
  end

  // Stage 2: add or subtract, normalize, truncate.
  logic [24:0] sum;
  logic [25:0] diff, norm;
  logic [4:0]  lz;
  logic        diff_zero;
  logic [7:0]  exp_sub;

  assign sum  = {1'b0, s1_q.lg.mant} + {1'b0, s1_q.sm_mant};
  assign diff = {1'b0, s1_q.lg.mant, 1'b0} - {1'b0, s1_q.sm_mant, s1_q.guard};

  fpu_norm_lzc u_norm_lzc (
    .in_i    (diff),
    .shift_o (lz),
    .norm_o  (norm),
    .zero_o  (diff_zero)
  );

  // Normalized leading one sits at bit 24 of diff, so the net shift is lz - 1.
  assign exp_sub = s1_q.lg.exp + 8'd1 - {3'b000, lz};

  always_comb begin
    y_d = FTZ_ZERO;
    if (s1_q.eff_add) begin
      if (sum == '0) begin
        y_d = FTZ_ZERO;
      end else if (sum[24]) begin
        y_d = {s1_q.lg.sign, s1_q.lg.exp + 8'd1, sum[23:1]};
      end else begin
        y_d = {s1_q.lg.sign, s1_q.lg.exp, sum[22:0]};
      end
    end else if (!diff_zero) begin
      y_d = {s1_q.lg.sign, exp_sub, 23'(norm >> 2)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      y_q        <= FTZ_ZERO;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) y_q <= y_d;
      end
    end
  end

endmodule

// File: tb/tb_fsub_pipe.sv
// Directed vector and handshake-sequence bench for fsub_pipe.
module tb_fsub_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x1, x2, y;
  logic        in_ready_ng, out_valid_ng;
  logic [31:0] y_ng;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  fsub_pipe #(.GB_EN(1'b1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  fsub_pipe #(.GB_EN(1'b0)) dut_ng (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready_ng),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid_ng),
    .out_ready (out_ready),
    .y         (y_ng)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        chk_ng;
    logic [31:0] y_ng;
  } vec_t;

  vec_t vecs[10];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{"3_minus_1",     32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 32'h0};
    vecs[1] = '{"1_minus_1",     32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 32'h0};
    vecs[2] = '{"1_minus_m1",    32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 32'h0};
    vecs[3] = '{"guard_d24",     32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 1'b1, 32'h3F800000};
    vecs[4] = '{"ftz_x1",        32'h00000001, 32'h3F800000, 32'hBF800000, 1'b0, 32'h0};
    vecs[5] = '{"ftz_x2",        32'h3F800000, 32'h007FFFFF, 32'h3F800000, 1'b0, 32'h0};
    vecs[6] = '{"2_minus_3",     32'h40000000, 32'h40400000, 32'hBF800000, 1'b0, 32'h0};
    vecs[7] = '{"1p5_minus_m1p5", 32'h3FC00000, 32'hBFC00000, 32'h40400000, 1'b0, 32'h0};
    vecs[8] = '{"m5_minus_3",    32'hC0A00000, 32'h40400000, 32'hC1000000, 1'b0, 32'h0};
    vecs[9] = '{"m0_minus_0",    32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 32'h0};

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x1        = '0;
    x2        = '0;
    step;
    step;
    rstn = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_in_ready_ng", 32'(in_ready_ng), 32'd1);

    // One op at a time, two-cycle latency, single-cycle output pulse.
    for (int i = 0; i < 10; i++) begin
      x1       = vecs[i].a;
      x2       = vecs[i].b;
      in_valid = 1'b1;
      step;
      chk({vecs[i].name, "_bubble"}, 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      step;
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      chk(vecs[i].name, y, vecs[i].y);
      if (vecs[i].chk_ng) begin
        chk({vecs[i].name, "_noguard_valid"}, 32'(out_valid_ng), 32'd1);
        chk({vecs[i].name, "_noguard"}, y_ng, vecs[i].y_ng);
      end
    end
    step;
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: A, B fill the pipe, C waits until the consumer releases.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x1 = vecs[0].a; x2 = vecs[0].b;
    #1;
    chk("bp_accept_a", 32'(in_ready), 32'd1);
    step;
    x1 = vecs[6].a; x2 = vecs[6].b;
    #1;
    chk("bp_accept_b", 32'(in_ready), 32'd1);
    step;
    x1 = vecs[8].a; x2 = vecs[8].b;
    #1;
    chk("bp_block_c", 32'(in_ready), 32'd0);
    chk("bp_valid_a", 32'(out_valid), 32'd1);
    chk("bp_y_a", y, vecs[0].y);
    step;
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_y_a", y, vecs[0].y);
    step;
    chk("bp_hold2_y_a", y, vecs[0].y);
    chk("bp_hold2_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    step;
    in_valid = 1'b0;
    chk("bp_valid_b", 32'(out_valid), 32'd1);
    chk("bp_y_b", y, vecs[6].y);
    step;
    chk("bp_valid_c", 32'(out_valid), 32'd1);
    chk("bp_y_c", y, vecs[8].y);
    step;
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset with two ops in flight discards both.
    in_valid = 1'b1;
    x1 = vecs[6].a; x2 = vecs[6].b;
    step;
    x1 = vecs[8].a; x2 = vecs[8].b;
    step;
    in_valid = 1'b0;
    chk("mid_inflight_valid", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    step;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_y", y, 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fsub_pipe.md
Name: fsub_pipe

Overview:
- Pipelined single-precision floating-point subtractor, y = x1 - x2, for the ray-tracer FPU.
- Complements the combinational adder: subtraction is a first-class operation here, not operand negation by the caller.
- Two register stages with valid/ready handshake on both sides, so the core scheduler can stall it.
- Flush-to-zero, truncating arithmetic matching the rest of the FPU.

Parameters:
- GB_EN, 1, 1 = use one guard bit on the shifted smaller mantissa during effective subtraction; 0 = plain truncation.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- x1  in  32  minuend, IEEE-754 single
- x2  in  32  subtrahend, IEEE-754 single
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  32  x1 - x2

Behaviour:
- Interface: one clock `clk`; reset `rstn` is synchronous and active-low.
- Reset: s1_valid = 0, s2_valid = 0, out_valid = 0, y = 32'h0. in_ready = 1 in the first cycle after reset.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput 1/cycle.
- Pipeline advance:
  - s2 loads when !s2_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = that s1 load condition (combinational from out_ready; no skid buffer).
- Stall: at most 2 results are held. Held y and out_valid stay stable until consumed. Order is preserved.
- Stage 1 (unpack/align, registered):
  - Any operand with exp == 0 becomes +0, i.e. sign 0 and mantissa 0.
  - Negate x2's sign bit. eff_add = (s1 == ~s2).
  - Larger operand = larger of the x[30:0] values compared as unsigned integers; tie selects x2.
  - Result sign = sign of the larger operand (x2's sign negated).
  - d = exp_large - exp_small (8-bit).
  - If d > 24, smaller mantissa and guard bit are 0. Otherwise smaller mantissa = {1, mant} >> d and guard bit = bit d-1 of it (0 when d == 0).
- Stage 2 (add/normalize, registered into y):
  - Effective add: 25-bit sum. If bit24 is set, shift right 1 and exp+1.
  - Effective subtract: 26-bit {large, 0} - {small, guard}. Normalize left by the leading-one position of bits [25:1]; bits shifted in below use the guard-difference LSB, then zeros. Exponent decremented by the shift count.
  - Rounding: truncation only.
  - Exact-zero mantissa: y = 32'h0000_0000 (+0 regardless of signs).
  - Exponent overflow/underflow: not detected. The 8-bit exponent wraps; callers guarantee range. No NaN/Inf handling.
- Reset mid-operation: all in-flight results are discarded, out_valid = 0 the next cycle, no partial output.

Decomposition:
- Shared package fpu_pkg:
  - Field widths EXP_W = 8, MANT_W = 23.
  - FTZ zero constant.
  - Struct {sign, exp[7:0], mant24[23:0]} for unpacked floats.
- Sub-module fpu_norm_lzc: 26-bit leading-one detector and left-normalizer returning shift count and normalized mantissa. Reusable by fadd and future fmul/ftoi.
- Pipeline control stays in fsub_pipe.

Test Plan:
- x1 = 0x40400000 (3.0), x2 = 0x3F800000 (1.0), out_ready = 1 -> y = 0x40000000 two cycles later, out_valid pulses 1 cycle.
- 0x3F800000 - 0x3F800000 -> y = 0x00000000. Also 0x3F800000 - 0xBF800000 -> y = 0x40000000 (effective add, exp+1).
- 0x3F800000 - 0x33800000 (2^-24, d = 24, guard path) -> y = 0x3F7FFFFF. With GB_EN = 0 -> y = 0x3F800000.
- Denormal flush: 0x00000001 - 0x3F800000 -> y = 0xBF800000. Also 0x3F800000 - 0x007FFFFF -> y = 0x3F800000.
- Backpressure:
  - Hold out_ready = 0 and present 3 back-to-back ops (A, B, C); in_ready drops after A and B are accepted.
  - Release out_ready: results A, B, C emerge in order, each held stable while stalled.
- Assert rstn = 0 for 1 cycle with 2 ops in flight -> out_valid = 0, y = 0 next cycle; no stale result appears afterward.
